// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions of the digit select fields returned by decode_digit.
    localparam int unsigned NEG = 2;
    localparam int unsigned ONE = 1;
    localparam int unsigned TWO = 0;

    function automatic int unsigned iter_count(input int unsigned width);
        return width / 2 + 1;
    endfunction

    function automatic logic [2:0] decode_digit(input logic [2:0] window);
        logic [2:0] sel;
        sel = '0;
        case (window)
            3'b001, 3'b010: sel[ONE] = 1'b1;
            3'b011:         sel[TWO] = 1'b1;
            3'b100:         begin sel[NEG] = 1'b1; sel[TWO] = 1'b1; end
            3'b101, 3'b110: begin sel[NEG] = 1'b1; sel[ONE] = 1'b1; end
            default:        sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth4_digit_sel.sv
// Combinational Booth digit selector: maps a 3-bit recode window to the
// chosen multiple of the multiplicand, inverted with carry-in when negative.
module booth4_digit_sel
    import booth_pkg::*;
#(
    parameter int unsigned AW = 10
) (
    input  logic [2:0]    window,
    input  logic [AW-1:0] mcand,
    output logic [AW-1:0] multiple,
    output logic          cin
);

    logic [2:0]    sel;
    logic [AW-1:0] mag;

    always_comb begin
        sel = decode_digit(window);
        mag = '0;
        if (sel[ONE]) begin
            mag = mcand;
        end else if (sel[TWO]) begin
            mag = {mcand[AW-2:0], 1'b0};
        end
        multiple = sel[NEG] ? ~mag : mag;
        cin      = sel[NEG];
    end

endmodule

// File: rtl/booth4_seq_mult.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready handshakes.
// Define BOOTH_SIGNED_EN to add the tc port for per-operation two's-complement mode.
module booth4_seq_mult
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef BOOTH_SIGNED_EN
    input  logic               tc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z
);

    localparam int unsigned ITER = iter_count(WIDTH);
    localparam int unsigned AW   = WIDTH + 2;
    localparam int unsigned MW   = WIDTH + 3;
    localparam int unsigned PW   = 2 * WIDTH + 4;
    localparam int unsigned CW   = $clog2(ITER + 1);

    state_t          state;
    logic [AW-1:0]   mcand;
    logic [MW-1:0]   mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic            a_ext;
    logic            b_ext;
    logic [AW-1:0]   multiple;
    logic            cin;
    logic [AW-1:0]   sum;
    logic [PW-1:0]   acc_next;

`ifdef BOOTH_SIGNED_EN
    assign a_ext = tc & a[WIDTH-1];
    assign b_ext = tc & b[WIDTH-1];
`else
    assign a_ext = 1'b0;
    assign b_ext = 1'b0;
`endif

    booth4_digit_sel #(.AW(AW)) u_digit_sel (
        .window   (mplier[2:0]),
        .mcand    (mcand),
        .multiple (multiple),
        .cin      (cin)
    );

    // Upper partial sum always fits in AW signed bits, so the shift can take its sign bit.
    always_comb begin
        sum      = acc[PW-1 -: AW] + multiple + AW'(cin);
        acc_next = {sum[AW-1], sum[AW-1], sum, acc[AW-1:2]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            z      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {a_ext, a_ext, a};
                        mplier <= {b_ext, b_ext, b, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= {mplier[MW-1], mplier[MW-1], mplier[MW-1:2]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        z     <= acc_next[2*WIDTH-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule
